// File: rtl/key_evt_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : key_evt_pkg
//  Purpose  : Shared state encoding and default timing constants for the
//             per-key event classifier.
//  Revision : 1.0 - initial release
// ============================================================================
package key_evt_pkg;

    localparam int LONG_CYC_DEF = 50_000_000;
    localparam int DBL_CYC_DEF  = 15_000_000;
    localparam int CNT_W_DEF    = 26;

    typedef enum logic [2:0] {
        WAIT_REL = 3'd0,
        IDLE     = 3'd1,
        PRESS1   = 3'd2,
        LONG     = 3'd3,
        GAP      = 3'd4,
        PRESS2   = 3'd5
    } key_state_e;

endpackage : key_evt_pkg
`default_nettype wire

// File: rtl/key_event_classifier_if.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_classifier_if
//  Purpose  : Debounced key levels in, classified key events out.
//  Revision : 1.0 - initial release
// ============================================================================
interface key_event_classifier_if #(
    parameter int NUM_KEYS = 3
);
    logic [NUM_KEYS-1:0] key_n;
    logic [NUM_KEYS-1:0] short_p;
    logic [NUM_KEYS-1:0] long_p;
    logic [NUM_KEYS-1:0] double_p;
    logic [NUM_KEYS-1:0] held;

    modport master (
        output key_n,
        input  short_p,
        input  long_p,
        input  double_p,
        input  held
    );

    modport slave (
        input  key_n,
        output short_p,
        output long_p,
        output double_p,
        output held
    );
endinterface : key_event_classifier_if
`default_nettype wire

// File: rtl/key_evt_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : key_evt_fsm
//  Purpose  : Single-key short / long / double press classifier with one
//             shared duration counter and registered event outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module key_evt_fsm
    import key_evt_pkg::*;
#(
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int DBL_CYC  = DBL_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_short_p,
    output logic o_long_p,
    output logic o_double_p,
    output logic o_held
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    if ((LONG_CYC < 2) || (DBL_CYC < 2)) begin : g_param_min_check
        $error("key_evt_fsm: LONG_CYC and DBL_CYC must both be >= 2");
    end

    if ((((LONG_CYC - 1) >> CNT_W) != 0) || (((DBL_CYC - 1) >> CNT_W) != 0)) begin : g_param_width_check
        $error("key_evt_fsm: CNT_W too narrow for LONG_CYC/DBL_CYC");
    end

    key_state_e       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             short_q,  short_d;
    logic             long_q,   long_d;
    logic             double_q, double_d;
    logic             held_q,   held_d;
    logic             w_pressed;

    assign w_pressed = ~i_key_n;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        short_d  = 1'b0;
        long_d   = 1'b0;
        double_d = 1'b0;

        case (state_q)
            WAIT_REL: begin
                if (!w_pressed) state_d = IDLE;
            end
            IDLE: begin
                if (w_pressed) begin
                    state_d = PRESS1;
                    cnt_d   = '0;
                end
            end
            PRESS1: begin
                // Release takes priority over reaching the long threshold.
                if (!w_pressed) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            LONG: begin
                if (!w_pressed) state_d = IDLE;
            end
            GAP: begin
                // A press on the final gap cycle still counts as a double.
                if (w_pressed) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            PRESS2: begin
                if (!w_pressed) begin
                    state_d  = IDLE;
                    double_d = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_REL;
                cnt_d   = '0;
            end
        endcase

        held_d = (state_d == LONG);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= WAIT_REL;
            cnt_q    <= '0;
            short_q  <= 1'b0;
            long_q   <= 1'b0;
            double_q <= 1'b0;
            held_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            short_q  <= short_d;
            long_q   <= long_d;
            double_q <= double_d;
            held_q   <= held_d;
        end
    end

    assign o_short_p  = short_q;
    assign o_long_p   = long_q;
    assign o_double_p = double_q;
    assign o_held     = held_q;

endmodule : key_evt_fsm
`default_nettype wire

// File: rtl/key_event_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : key_event_classifier
//  Purpose  : Classifies each debounced key into short / long / double press
//             events using one independent key_evt_fsm per key.
//  Revision : 1.0 - initial release
// ============================================================================
module key_event_classifier
    import key_evt_pkg::*;
#(
    parameter int NUM_KEYS = 3,
    parameter int LONG_CYC = LONG_CYC_DEF,
    parameter int DBL_CYC  = DBL_CYC_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                   clk,
    input  logic                   rst_n,
    key_event_classifier_if.slave  evt
);

    logic [NUM_KEYS-1:0] w_short_p;
    logic [NUM_KEYS-1:0] w_long_p;
    logic [NUM_KEYS-1:0] w_double_p;
    logic [NUM_KEYS-1:0] w_held;

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_evt_fsm #(
            .LONG_CYC (LONG_CYC),
            .DBL_CYC  (DBL_CYC),
            .CNT_W    (CNT_W)
        ) u_fsm (
            .clk        (clk),
            .rst_n      (rst_n),
            .i_key_n    (evt.key_n[i]),
            .o_short_p  (w_short_p[i]),
            .o_long_p   (w_long_p[i]),
            .o_double_p (w_double_p[i]),
            .o_held     (w_held[i])
        );
    end

    assign evt.short_p  = w_short_p;
    assign evt.long_p   = w_long_p;
    assign evt.double_p = w_double_p;
    assign evt.held     = w_held;

endmodule : key_event_classifier
`default_nettype wire

// File: tb/tb_key_event_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : tb_key_event_classifier
//  Purpose  : Directed scoreboard bench for key_event_classifier
//             (LONG_CYC=20, DBL_CYC=10, three keys).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_key_event_classifier;

    localparam int NK     = 3;
    localparam int LONG_C = 20;
    localparam int DBL_C  = 10;
    localparam int K_SHORT  = 0;
    localparam int K_LONG   = 1;
    localparam int K_DOUBLE = 2;

    typedef struct {
        int key;
        int kind;
        int cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   e;
    exp_t exp_q[$];

    key_event_classifier_if #(.NUM_KEYS(NK)) evt_if ();

    key_event_classifier #(
        .NUM_KEYS (NK),
        .LONG_CYC (LONG_C),
        .DBL_CYC  (DBL_C),
        .CNT_W    (5)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .evt   (evt_if)
    );

    always #10 clk = ~clk;

    function automatic string kname(input int kd);
        if (kd == K_SHORT) return "short";
        if (kd == K_LONG)  return "long";
        return "double";
    endfunction

    task automatic expect_evt(input int key, input int kind, input int at);
        exp_t it;
        it.key  = key;
        it.kind = kind;
        it.cyc  = at;
        exp_q.push_back(it);
    endtask

    // Every observed pulse must consume a matching expectation at the right cycle.
    task automatic check_outputs();
        logic [NK-1:0] pv;
        int idx;
        for (int kd = 0; kd < 3; kd++) begin
            pv = (kd == K_SHORT) ? evt_if.short_p :
                 (kd == K_LONG)  ? evt_if.long_p  : evt_if.double_p;
            for (int k = 0; k < NK; k++) begin
                if (pv[k] === 1'b1) begin
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (idx < 0 && exp_q[j].key == k && exp_q[j].kind == kd) idx = j;
                    n_tests++;
                    assert (idx >= 0) else begin
                        n_fail++;
                        $error("FAIL unexpected_%s key%0d: observed pulse at cycle %0d, expected none",
                               kname(kd), k, cyc);
                    end
                    if (idx >= 0) begin
                        n_tests++;
                        assert (cyc === exp_q[idx].cyc) else begin
                            n_fail++;
                            $error("FAIL timing_%s key%0d: observed cycle %0d, expected cycle %0d",
                                   kname(kd), k, cyc, exp_q[idx].cyc);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check_outputs();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic drain(input string name);
        n_tests++;
        assert (exp_q.size() === 0) else begin
            n_fail++;
            $error("FAIL drain_%s: observed %0d events never seen, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic check_zero(input string name);
        logic [4*NK-1:0] all_o;
        all_o = {evt_if.short_p, evt_if.long_p, evt_if.double_p, evt_if.held};
        n_tests++;
        assert (all_o === '0) else begin
            n_fail++;
            $error("FAIL %s: observed outputs %h, expected 0", name, all_o);
        end
    endtask

    task automatic check_held(input string name, input int k, input logic exp_v);
        n_tests++;
        assert (evt_if.held[k] === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed held[%0d]=%b, expected %b", name, k, evt_if.held[k], exp_v);
        end
    endtask

    initial begin
        rst_n        = 1'b0;
        evt_if.key_n = '1;
        ticks(3);
        check_zero("reset_state");
        rst_n = 1'b1;
        ticks(2);

        // Short press on key0: 5 pressed samples, short DBL_C after first release.
        e = cyc;
        evt_if.key_n[0] = 1'b0;
        expect_evt(0, K_SHORT, e + 6 + DBL_C);
        ticks(5);
        evt_if.key_n[0] = 1'b1;
        ticks(DBL_C + 5);
        drain("short");

        // Long press on key1 held 30 samples.
        e = cyc;
        evt_if.key_n[1] = 1'b0;
        expect_evt(1, K_LONG, e + 1 + LONG_C);
        ticks(LONG_C);
        check_held("held_before_long", 1, 1'b0);
        tick();
        check_held("held_at_long", 1, 1'b1);
        ticks(9);
        evt_if.key_n[1] = 1'b1;
        check_held("held_last_pressed", 1, 1'b1);
        tick();
        check_held("held_after_release", 1, 1'b0);
        ticks(DBL_C + 5);
        drain("long");

        // Double press on key2: 5 down / 4 up / 5 down / up.
        e = cyc;
        evt_if.key_n[2] = 1'b0;
        expect_evt(2, K_DOUBLE, e + 15);
        ticks(5);
        evt_if.key_n[2] = 1'b1;
        ticks(4);
        evt_if.key_n[2] = 1'b0;
        ticks(5);
        evt_if.key_n[2] = 1'b1;
        ticks(DBL_C + 5);
        drain("double");

        // Second press sampled on the last gap cycle (cnt == DBL_C-1) -> double.
        e = cyc;
        evt_if.key_n[0] = 1'b0;
        expect_evt(0, K_DOUBLE, e + 6 + DBL_C);
        ticks(3);
        evt_if.key_n[0] = 1'b1;
        ticks(DBL_C);
        evt_if.key_n[0] = 1'b0;
        ticks(2);
        evt_if.key_n[0] = 1'b1;
        ticks(DBL_C + 5);
        drain("gap_in");

        // One cycle later -> short, then a fresh sequence ending in another short.
        e = cyc;
        evt_if.key_n[0] = 1'b0;
        expect_evt(0, K_SHORT, e + 4 + DBL_C);
        expect_evt(0, K_SHORT, e + 7 + 2 * DBL_C);
        ticks(3);
        evt_if.key_n[0] = 1'b1;
        ticks(DBL_C + 1);
        evt_if.key_n[0] = 1'b0;
        ticks(2);
        evt_if.key_n[0] = 1'b1;
        ticks(DBL_C + 5);
        drain("gap_out");

        // key0 held through reset: silent until released, then a normal short.
        evt_if.key_n[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        check_zero("reset_held_key");
        tick();
        rst_n = 1'b1;
        ticks(LONG_C + 5);
        evt_if.key_n[0] = 1'b1;
        ticks(2);
        e = cyc;
        evt_if.key_n[0] = 1'b0;
        expect_evt(0, K_SHORT, e + 4 + DBL_C);
        ticks(3);
        evt_if.key_n[0] = 1'b1;
        ticks(DBL_C + 5);
        drain("reset_held");

        // Reset while key1 is in long-hold clears held immediately.
        e = cyc;
        evt_if.key_n[1] = 1'b0;
        expect_evt(1, K_LONG, e + 1 + LONG_C);
        ticks(LONG_C + 2);
        check_held("held_before_reset", 1, 1'b1);
        rst_n = 1'b0;
        #1;
        check_zero("reset_in_long");
        evt_if.key_n[1] = 1'b1;
        ticks(2);
        rst_n = 1'b1;
        ticks(3);
        drain("reset_long");

        // Reset during key1 PRESS1 discards the pending sequence.
        evt_if.key_n[1] = 1'b0;
        ticks(8);
        rst_n = 1'b0;
        evt_if.key_n[1] = 1'b1;
        #1;
        check_zero("reset_in_press1");
        ticks(2);
        rst_n = 1'b1;
        ticks(LONG_C + DBL_C);
        drain("reset_press1");

        // key0 short and key2 long started together.
        e = cyc;
        evt_if.key_n[0] = 1'b0;
        evt_if.key_n[2] = 1'b0;
        expect_evt(0, K_SHORT, e + 6 + DBL_C);
        expect_evt(2, K_LONG,  e + 1 + LONG_C);
        ticks(5);
        evt_if.key_n[0] = 1'b1;
        ticks(LONG_C);
        evt_if.key_n[2] = 1'b1;
        ticks(DBL_C + 5);
        drain("simultaneous");

        // Release on the same edge the counter sits at LONG_C-1 -> GAP, no long.
        e = cyc;
        evt_if.key_n[1] = 1'b0;
        expect_evt(1, K_SHORT, e + 21 + DBL_C);
        ticks(LONG_C);
        evt_if.key_n[1] = 1'b1;
        tick();
        check_held("held_release_at_threshold", 1, 1'b0);
        ticks(DBL_C + 5);
        drain("release_threshold");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_key_event_classifier
`default_nettype wire
